// File: rtl/dram_requester.sv
// Burst initiator for the 8-lane byte DRAM: takes one read/write burst over valid/ready,
// drives the lanes until the access completes, then returns data or a completion.
module dram_requester #(
    parameter int unsigned N_LANES = 8,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned WR_HOLD = 22,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned GAP     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rdwr,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [3:0]                req_len,
    input  logic [N_LANES*8-1:0]      req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_rdwr,
    output logic [N_LANES*8-1:0]      resp_data,
    output logic                      resp_err,
    output logic [N_LANES-1:0]        dram_en,
    output logic                      dram_rdwr,
    output logic [N_LANES*8-1:0]      dram_data_in,
    output logic [N_LANES*ADDR_W-1:0] dram_addr,
    input  logic [N_LANES*8-1:0]      dram_data_out,
    input  logic [N_LANES-1:0]        dram_valid
);

    localparam int unsigned DATA_W = N_LANES * 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + WR_HOLD + GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      req_ready_d;
    logic                      resp_valid_d;
    logic                      resp_rdwr_d;
    logic [DATA_W-1:0]         resp_data_d;
    logic                      resp_err_d;
    logic [N_LANES-1:0]        dram_en_d;
    logic                      dram_rdwr_d;
    logic [DATA_W-1:0]         dram_data_in_d;
    logic [N_LANES*ADDR_W-1:0] dram_addr_d;

    logic [3:0]                eff_len;
    logic [N_LANES-1:0]        req_mask;
    logic                      lanes_ok;
    logic                      access_done;

    // Next state and next registered outputs; dram_en doubles as the lane mask during ACCESS.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_ready_d    = 1'b0;
        resp_valid_d   = resp_valid;
        resp_rdwr_d    = resp_rdwr;
        resp_data_d    = resp_data;
        resp_err_d     = resp_err;
        dram_en_d      = dram_en;
        dram_rdwr_d    = dram_rdwr;
        dram_data_in_d = dram_data_in;
        dram_addr_d    = dram_addr;
        access_done    = 1'b0;

        eff_len  = (req_len > 4'(N_LANES)) ? 4'(N_LANES) : req_len;
        req_mask = '0;
        for (int i = 0; i < N_LANES; i++) begin
            req_mask[i] = (4'(i) < eff_len);
        end
        lanes_ok = ((dram_valid & dram_en) == dram_en);

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready) begin
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    resp_rdwr_d = req_rdwr;
                    resp_data_d = '0;
                    if (req_len == 4'd0) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = S_ACCESS;
                        resp_err_d  = 1'b0;
                        dram_en_d   = req_mask;
                        dram_rdwr_d = req_rdwr;
                        for (int i = 0; i < N_LANES; i++) begin
                            dram_addr_d[i*ADDR_W +: ADDR_W] =
                                req_mask[i] ? req_addr + ADDR_W'(i) : '0;
                            dram_data_in_d[i*8 +: 8] =
                                req_mask[i] ? req_wdata[i*8 +: 8] : 8'h00;
                        end
                    end
                end
            end

            S_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dram_rdwr) begin
                    if (lanes_ok) begin
                        access_done = 1'b1;
                        for (int i = 0; i < N_LANES; i++) begin
                            resp_data_d[i*8 +: 8] = dram_en[i] ? dram_data_out[i*8 +: 8] : 8'h00;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        access_done = 1'b1;
                        resp_err_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(WR_HOLD - 1)) begin
                    access_done = 1'b1;
                end
                if (access_done) begin
                    state_d        = S_RESP;
                    resp_valid_d   = 1'b1;
                    dram_en_d      = '0;
                    dram_rdwr_d    = 1'b0;
                    dram_addr_d    = '0;
                    dram_data_in_d = '0;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_GAP;
                    resp_valid_d = 1'b0;
                    cnt_d        = '0;
                end
            end

            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdwr    <= 1'b0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            dram_en      <= '0;
            dram_rdwr    <= 1'b0;
            dram_data_in <= '0;
            dram_addr    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready    <= req_ready_d;
            resp_valid   <= resp_valid_d;
            resp_rdwr    <= resp_rdwr_d;
            resp_data    <= resp_data_d;
            resp_err     <= resp_err_d;
            dram_en      <= dram_en_d;
            dram_rdwr    <= dram_rdwr_d;
            dram_data_in <= dram_data_in_d;
            dram_addr    <= dram_addr_d;
        end
    end

endmodule

// File: tb/tb_dram_requester.sv
// Bench for dram_requester: directed scenarios plus random bursts against a 256-byte
// DRAM model and a reference byte memory.
module tb_dram_requester;

    localparam int WR_HOLD = 22;
    localparam int TIMEOUT = 64;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_rdwr;
    logic [63:0]  req_addr;
    logic [3:0]   req_len;
    logic [63:0]  req_wdata;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_rdwr;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic [7:0]   dram_en;
    logic         dram_rdwr;
    logic [63:0]  dram_data_in;
    logic [511:0] dram_addr;
    logic [63:0]  dram_data_out;
    logic [7:0]   dram_valid;

    int           errors = 0;
    int           checks = 0;
    logic [63:0]  last_data;

    // DRAM model state
    logic [7:0]   mem [256];
    bit           mem_clr;
    int           en_cnt = 0;
    int           rd_delay;
    logic [7:0]   stale;

    // Reference memory, updated from the requests themselves
    logic [7:0]   ref_mem [256];

    dram_requester dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rdwr      (req_rdwr),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdwr     (resp_rdwr),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .dram_en       (dram_en),
        .dram_rdwr     (dram_rdwr),
        .dram_data_in  (dram_data_in),
        .dram_addr     (dram_addr),
        .dram_data_out (dram_data_out),
        .dram_valid    (dram_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM: byte memory decoded on the low 8 address bits, one-cycle read data, valids
    // raised once enables have been held rd_delay cycles; disabled lanes carry garbage.
    always @(posedge clk) begin
        en_cnt <= (dram_en != 8'h00) ? en_cnt + 1 : 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_clr)
                mem[i*32 + 0] <= 8'h00;
            if (dram_en[i] && !dram_rdwr)
                mem[dram_addr[i*64 +: 8]] <= dram_data_in[i*8 +: 8];
            dram_data_out[i*8 +: 8] <= dram_en[i] ? mem[dram_addr[i*64 +: 8]] : 8'($urandom);
        end
        if (mem_clr)
            for (int j = 0; j < 256; j++) mem[j] <= 8'h00;
    end

    assign dram_valid = ((dram_rdwr && en_cnt >= rd_delay) ? dram_en : 8'h00) | stale;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete burst: request, access window, response (with back-pressure), gap.
    task automatic do_txn(input logic rdwr, input logic [63:0] addr, input logic [3:0] len,
                          input logic [63:0] wdata, input int delay, input int rwait);
        int           eff, n, cyc, exp_cyc;
        logic [7:0]   mask;
        logic [511:0] exp_addr;
        logic [63:0]  exp_din, exp_data, hold_data;
        logic         exp_err, hold_err;
        bit           stable;

        eff = (len > 4'd8) ? 8 : int'(len);
        mask = '0; exp_addr = '0; exp_din = '0; exp_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < eff) begin
                mask[i] = 1'b1;
                exp_addr[i*64 +: 64] = addr + 64'(i);
                exp_din[i*8 +: 8]    = wdata[i*8 +: 8];
            end
        end
        exp_err = (len == 4'd0) || (rdwr && delay >= TIMEOUT);
        exp_cyc = rdwr ? ((delay + 1 < TIMEOUT) ? delay + 1 : TIMEOUT) : WR_HOLD;
        if (rdwr && !exp_err)
            for (int i = 0; i < eff; i++) exp_data[i*8 +: 8] = ref_mem[8'(addr + 64'(i))];

        rd_delay  = delay;
        req_valid = 1'b1;
        req_rdwr  = rdwr;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", n < 200, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        if (len != 4'd0) begin
            chk("en_mask", dram_en, mask);
            chk("dram_rdwr", dram_rdwr, rdwr);
            chk("lane_addr", dram_addr, exp_addr);
            chk("lane_wdata", dram_data_in, exp_din);
            chk("resp_during_access", resp_valid, 0);
            cyc = 1;
            stable = 1'b1;
            while (dram_en != 8'h00 && cyc < 200) begin
                @(posedge clk); #1;
                if (dram_en != 8'h00) begin
                    cyc++;
                    if (dram_en !== mask || dram_addr !== exp_addr || dram_data_in !== exp_din)
                        stable = 1'b0;
                end
            end
            chk("access_stable", stable, 1);
            chk("access_cycles", cyc, exp_cyc);
            if (!rdwr)
                for (int i = 0; i < eff; i++) ref_mem[8'(addr + 64'(i))] = wdata[i*8 +: 8];
        end else begin
            chk("len0_no_dram", dram_en, 0);
        end

        chk("resp_valid", resp_valid, 1);
        chk("resp_rdwr", resp_rdwr, rdwr);
        chk("resp_err", resp_err, exp_err);
        chk("resp_data", resp_data, exp_data);
        chk("resp_req_ready", req_ready, 0);
        last_data = resp_data;

        hold_data = resp_data;
        hold_err  = resp_err;
        stable    = 1'b1;
        repeat (rwait) begin
            @(posedge clk); #1;
            if (!resp_valid || resp_data !== hold_data || resp_err !== hold_err ||
                req_ready || dram_en != 8'h00)
                stable = 1'b0;
        end
        if (rwait > 0) chk("resp_hold", stable, 1);

        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", resp_valid, 0);
        chk("gap0", {req_ready, dram_en}, 0);
        @(posedge clk); #1;
        chk("gap1", {req_ready, dram_en}, 0);
        @(posedge clk); #1;
        chk("idle_ready", req_ready, 1);
    endtask

    initial begin
        bit seen;
        int n;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_rdwr   = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        stale      = 8'h00;
        rd_delay   = 1000;
        mem_clr    = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", req_ready, 0);
        mem_clr = 1'b0;
        reset   = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_req_ready", req_ready, 1);
        chk("post_reset_resp_valid", resp_valid, 0);
        chk("post_reset_dram_en", dram_en, 0);

        // Write then read back with a stale valid on a disabled lane
        do_txn(1'b0, 64'h10, 4'd4, 64'hDEADBEEF_A3A2A1A0, 1, 0);
        stale = 8'h80;
        do_txn(1'b1, 64'h10, 4'd4, 64'h0, 21, 0);
        stale = 8'h00;
        chk("readback_a0_a3", last_data, 64'h00000000_A3A2A1A0);

        // Address wrap, zero length, clamped length, timeout with back-pressure
        do_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 4'd8, 64'h0, 3, 1);
        do_txn(1'b1, 64'h40, 4'd0, 64'h0, 1, 2);
        do_txn(1'b0, 64'h30, 4'd13, 64'h0706050403020100, 1, 0);
        do_txn(1'b1, 64'h20, 4'd8, 64'h0, 1000, 5);

        // Reset in the middle of a write
        req_valid = 1'b1;
        req_rdwr  = 1'b0;
        req_addr  = 64'h80;
        req_len   = 4'd8;
        req_wdata = {$urandom, $urandom};
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_req_ready_wait", n < 200, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("abort_mid_access", dram_en, 8'hFF);
        for (int i = 0; i < 8; i++) ref_mem[8'h80 + i] = req_wdata[i*8 +: 8];
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_dram_en", dram_en, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_req_ready", req_ready, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_again", req_ready, 1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (resp_valid || dram_en != 8'h00) seen = 1'b1;
        end
        chk("abort_no_response", seen, 0);
        do_txn(1'b1, 64'h10, 4'd4, 64'h0, 5, 0);

        // Random bursts
        for (int k = 0; k < 12; k++) begin
            do_txn(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                   {$urandom, $urandom}, int'($urandom_range(1, 40)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_requester.md
Name: dram_requester

Overview:
- Initiator side of the 8-lane byte DRAM interface.
- Accepts one burst request (read or write, 1–8 consecutive bytes) from the upstream serializer/parser over a valid/ready handshake.
- Fans the burst out across DRAM lanes, holds the request stable until the access completes, then returns read data or a write completion on a response handshake.
- Sits between the ProtoBuf engine datapath and the DRAM model.

Parameters:
- N_LANES, 8: byte lanes per burst; fixed to the DRAM lane count.
- ADDR_W, 64: byte address width per lane.
- WR_HOLD, 22: cycles dram_en is held for a write before completion is declared; the DRAM gives no write acknowledge.
- TIMEOUT, 64: maximum cycles to wait for read valids before aborting with an error.
- GAP, 2: idle cycles with dram_en=0 after each transaction.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-low reset (0 = reset).
- req_valid, input, 1: request present.
- req_ready, output, 1: requester can accept a request.
- req_rdwr, input, 1: 1 = read, 0 = write.
- req_addr, input, ADDR_W: base byte address.
- req_len, input, 4: byte count, 1–8.
- req_wdata, input, N_LANES×8: write bytes; lane i is written to req_addr+i.
- resp_valid, output, 1: response present.
- resp_ready, input, 1: response consumer ready.
- resp_rdwr, output, 1: echo of the request type.
- resp_data, output, N_LANES×8: read bytes; disabled lanes are 0.
- resp_err, output, 1: len error or read timeout.
- dram_en, output, N_LANES: per-lane enable.
- dram_rdwr, output, 1: DRAM read/write select.
- dram_data_in, output, N_LANES×8: write data to the DRAM.
- dram_addr, output, N_LANES×ADDR_W: per-lane address.
- dram_data_out, input, N_LANES×8: read data from the DRAM.
- dram_valid, input, N_LANES: per-lane read valid.

Behaviour:
- Reset (reset=0 at a clk edge) forces state=IDLE and all outputs to 0 except req_ready. req_ready is 0 during reset and 1 on the first cycle after reset releases. Reset mid-transaction aborts it with no response; the captured request is discarded.
- States: IDLE, ACCESS, RESP, GAP.
- IDLE:
  - req_ready=1. A handshake (req_valid & req_ready) captures rdwr, addr, len and wdata into registers.
  - Lane mask: bit i = (i < eff_len), where eff_len = min(req_len, 8).
  - If req_len=0: go directly to RESP with resp_err=1, data 0; no DRAM activity.
  - Otherwise go to ACCESS.
- ACCESS:
  - dram_en=mask, dram_rdwr=captured rdwr, dram_addr[i]=addr+i (mod 2^ADDR_W, wrap allowed), dram_data_in[i]=wdata[i].
  - All DRAM outputs are stable for the whole state. Disabled lanes drive addr 0 and data 0.
  - A cycle counter starts at 0 on entry and increments every cycle.
  - Read: when (dram_valid & mask)==mask, capture dram_data_out for enabled lanes into resp_data and go to RESP with err=0. Capture happens in the same cycle the condition is first seen.
  - Read timeout: if the count reaches TIMEOUT-1 without completion, go to RESP with err=1 and resp_data=0.
  - Write: when the count reaches WR_HOLD-1, go to RESP with err=0.
- RESP:
  - dram_en=0; resp_valid=1; resp_* held stable until resp_ready.
  - On the handshake, go to GAP; resp_valid drops the next cycle.
  - req_ready=0 throughout.
- GAP:
  - dram_en=0 for exactly GAP cycles, then IDLE.
  - Requests arriving during GAP wait; they are not dropped.
- Single outstanding transaction. Throughput is at most one burst per (access + 1 + GAP + resp-wait) cycles.
- Latency:
  - Read: handshake → dram_en asserted next cycle; resp_valid is asserted 1 cycle after valids are observed.
  - Write: resp_valid is asserted WR_HOLD+1 cycles after the request handshake.
- req_len>8 is clamped to 8 and is not an error.
- Stale dram_valid bits on disabled lanes are ignored.
- No combinational path from req_valid to req_ready or from dram_valid to resp_valid.

Test Plan:
- Reset held low for 3 cycles, then released → req_ready=1, resp_valid=0, dram_en=0 on the first post-reset cycle.
- Write addr=0x10, len=4, wdata lanes 0–3 = 0xA0..0xA3 → dram_en=0x0F, dram_addr lanes = 0x10..0x13 for exactly 22 cycles; resp_valid with err=0; dram_en=0 for 2 cycles afterward.
- Read addr=0x10, len=4, DRAM model asserts valid after 21 cycles → resp_data = 0xA3A2A1A0 in the low bytes and 0 above, err=0; stale dram_valid bit 7 is ignored.
- Read len=8, addr=0xFFFF_FFFF_FFFF_FFFC → lane addresses FC, FD, FE, FF, 0, 1, 2, 3 (wrapped); len=0 → immediate resp_err=1 with dram_en never asserted.
- Read with dram_valid held at 0 → resp_err=1 exactly 64 cycles after dram_en rises; resp_ready held low for 5 cycles keeps the response stable and req_ready=0.
- Reset pulsed low during ACCESS of a write → dram_en=0 and no response; a subsequent read completes normally.
